// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the data width, the default clocks-per-bit and the 3-bit FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;   // 50 MHz / 115200

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_module_if.sv
// UART receiver pin/byte bundle.
//   rx_en_sig, rx_pin_in               : line side and enable, driven by the master
//   rx_data, rx_done_sig, frame_err_sig,
//   parity_err_sig, rx_busy            : receive results, driven by the receiver (slave)
interface uart_rx_module_if;
    import uart_pkg::*;

    logic                   rx_en_sig;
    logic                   rx_pin_in;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_done_sig;
    logic                   frame_err_sig;
    logic                   parity_err_sig;
    logic                   rx_busy;

    modport master (
        output rx_en_sig, rx_pin_in,
        input  rx_data, rx_done_sig, frame_err_sig, parity_err_sig, rx_busy
    );

    modport slave (
        input  rx_en_sig, rx_pin_in,
        output rx_data, rx_done_sig, frame_err_sig, parity_err_sig, rx_busy
    );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Baud timer for the UART receiver.
// start_c loads a half-bit period, after which full-bit periods follow while run is high.
// sample_tick is a registered one-cycle pulse at each sample point; the counter
// reloads to 0 on every tick so periods never drift.
// Ports: clk, rstn (async active-low), start_c, run, sample_tick.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rstn,
    input  logic start_c,
    input  logic run,
    output logic sample_tick
);

    localparam int unsigned        CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic             half_q;
    logic             tc_hit_c;

    assign tc_hit_c = (cnt == (half_q ? HALF_TC : FULL_TC));

    // Counter: half period after start, full periods thereafter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            half_q      <= 1'b0;
            sample_tick <= 1'b0;
        end else if (start_c) begin
            cnt         <= '0;
            half_q      <= 1'b1;
            sample_tick <= 1'b0;
        end else if (run) begin
            sample_tick <= tc_hit_c;
            if (tc_hit_c) begin
                cnt    <= '0;
                half_q <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt         <= '0;
            half_q      <= 1'b0;
            sample_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver, 8 data bits LSB first, 1 stop bit; optional parity bit.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, PARITY_ODD selects sense).
// Ports: clk, rstn (async active-low), bus (uart_rx_module_if.slave):
//   rx_en_sig/rx_pin_in in; rx_data, rx_done_sig, frame_err_sig, parity_err_sig, rx_busy out.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rstn,
    uart_rx_module_if.slave   bus
);

    if (CLKS_PER_BIT < 8 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_module: CLKS_PER_BIT must be >= 8 and PARITY_ODD 0 or 1");
    end

    uart_state_e            state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift_reg;
    logic [UART_DATA_W-1:0] data_q;
    logic                   done_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   sample_tick;
    logic                   fall_c;
    logic                   start_c;
    logic                   run_c;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic            par_bit;
    logic            perr_q;
`endif

    assign fall_c  = rx_prev & ~rx_sync;
    assign start_c = (state == IDLE) & fall_c & bus.rx_en_sig;
    assign run_c   = (state == START) | (state == DATA) | (state == PARITY) | (state == STOP);

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .rstn        (rstn),
        .start_c     (start_c),
        .run         (run_c),
        .sample_tick (sample_tick)
    );

    // Synchroniser, edge register and receive FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta <= bus.rx_pin_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state   <= START;
                        busy_q  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    // Line back high at mid start bit is a glitch
                    if (sample_tick) begin
                        if (rx_sync) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        shift_reg <= {rx_sync, shift_reg[UART_DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_tick) begin
                        par_bit <= rx_sync;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample_tick) begin
                        if (rx_sync) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bit == ((^shift_reg) ^ PAR_SENSE)) begin
                                data_q <= shift_reg;
                                done_q <= 1'b1;
                            end else begin
                                perr_q <= 1'b1;
                            end
`else
                            data_q <= shift_reg;
                            done_q <= 1'b1;
`endif
                        end else begin
                            // Stop bit low: framing error or break; wait for line to idle
                            ferr_q <= 1'b1;
                            state  <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_done_sig   = done_q;
    assign bus.frame_err_sig = ferr_q;
    assign bus.rx_busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_sig = perr_q;
`else
    assign bus.parity_err_sig = 1'b0;
`endif

endmodule
